uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single UART transmitter between the bootloader echo path and the CPU serial-out port. Each requester owns a holding slot. A transmit sequencer grants the UART to one slot at a time, pulses `transmit`, waits for `tx_done`, then reports completion to the owner. While `booting` is high, only the bootloader is granted; otherwise the two requesters share the UART round-robin.

## Interface
- `IDLE_GAP`, default 2: idle cycles forced between the end of one frame (`tx_done`) and the next grant. 0 is legal.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `booting` in 1: high means CPU grants are blocked.
- `boot_data` in 8: bootloader byte.
- `boot_transmit` in 1: one-cycle write strobe for `boot_data`.
- `boot_busy` out 1: boot slot occupied.
- `boot_done` out 1: one-cycle pulse when a boot byte finishes.
- `cpu_data` in 8: CPU byte.
- `cpu_wr` in 1: one-cycle write strobe for `cpu_data`.
- `cpu_full` out 1: CPU storage full.
- `cpu_done` out 1: one-cycle pulse when a CPU byte finishes.
- `cpu_ovf` out 1: sticky flag, set when `cpu_wr` arrives while `cpu_full` is high.
- `tx_data` out 8: byte to the UART.
- `transmit` out 1: one-cycle start pulse to the UART.
- `tx_done` in 1: UART frame complete.
- `owner` out 1: 0 = boot, 1 = CPU. Valid while not in S_IDLE.

## Operation
- **Boot slot.** `boot_transmit` with `boot_busy`=0 loads `boot_data` and sets `boot_busy` on the next cycle. `boot_transmit` with `boot_busy`=1 is dropped silently.
- **CPU slot.** `cpu_wr` with `cpu_full`=0 stores `cpu_data`. `cpu_wr` with `cpu_full`=1 drops the byte and sets `cpu_ovf`. `cpu_ovf` clears only on `rst`.
- **Sequencer states.**
  - S_IDLE: arbitrate. Boot wins if `booting`=1. If both slots are pending and `booting`=0, grant the requester not granted last. The last-granted pointer resets to CPU, so boot wins the first tie.
  - S_START: `transmit`=1, `tx_data` = granted byte. Next state is S_WAIT.
  - S_WAIT: wait for `tx_done`. On `tx_done`, free the owner's slot (or pop the CPU FIFO) and pulse that owner's `*_done` for one cycle. Next state is S_GAP, or S_IDLE if `IDLE_GAP`=0.
  - S_GAP: count `IDLE_GAP` cycles, then go to S_IDLE.
- `tx_done` is ignored outside S_WAIT.
- **Simultaneous events.**
  - A write on the same cycle the slot frees is judged against the registered full/busy value, so it is dropped (and `cpu_ovf` is set for the CPU path).
  - `booting` rising while a CPU frame is in flight does not abort it. It only blocks further CPU grants.
- **Reset mid-frame.** Return to S_IDLE and empty both slots. Any later `tx_done` is ignored. The UART must be reset alongside this block.
- **Reset values.** `tx_data`=0, `transmit`=0, `boot_busy`=0, `boot_done`=0, `cpu_full`=0, `cpu_done`=0, `cpu_ovf`=0, `owner`=0.

## Timing
- All outputs are registered.
- Strobe accepted at cycle N, sequencer in S_IDLE, UART free: `transmit` is high at cycle N+2.
- `tx_data` is valid in the `transmit` cycle and is held until the next grant.
- `tx_done` sampled at cycle M: `*_done` is high at M+1, and the slot is free at M+1.
- The next `transmit` is no earlier than M+IDLE_GAP+3.
- Per-byte overhead excluding the UART is IDLE_GAP+3 cycles.

## Configuration
- `UART_TX_ARB_CPU_FIFO_EN` defined:
  - The CPU path is a 4-entry FIFO with 2-bit wrapping read and write pointers and a 3-bit count.
  - `cpu_full` means count = 4.
  - A push and a pop in the same cycle keep the count unchanged.
  - Bytes are sent in write order.
- Not defined: the CPU path is a single holding register, and `cpu_full` equals its occupied flag.

## Test plan
- **Boot echo.** `booting`=1, boot strobe 0xA5, `tx_done` 10 cycles after `transmit` -> one `transmit` with `tx_data`=0xA5 at N+2, and `boot_done` one cycle after `tx_done`.
- **CPU blocked during boot.** `booting`=1, `cpu_wr` 0x41 -> no grant while `booting`=1. `booting` drops -> 0x41 transmitted, `cpu_done` pulses.
- **Round-robin tie.** `booting`=0, boot 0x11 and CPU 0x22 written in the same cycle, repeated twice -> transmit order 0x11, 0x22, 0x11, 0x22.
- **Overflow.** Five `cpu_wr` back-to-back with the UART stalled -> FIFO build: four bytes accepted, `cpu_ovf`=1, bytes sent in order. Non-FIFO build: one byte accepted, `cpu_ovf`=1.
- **Gap.** `IDLE_GAP`=2, two pending bytes -> exactly 5 cycles from `tx_done` to the next `transmit`.
- **Reset mid-frame.** `rst` asserted in S_WAIT -> all outputs return to reset values; a stray `tx_done` afterwards produces no `*_done` pulse.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART between the boot echo slot and the CPU slot (FIFO when UART_TX_ARB_CPU_FIFO_EN is defined).
// Strobe to transmit in 2 cycles, tx_done to next transmit >= IDLE_GAP+3 cycles; writes into a full slot are dropped.

`ifdef UART_TX_ARB_CPU_FIFO_EN
// Small power-of-two FIFO: 0-cycle head, push ignored when full, pop ignored when empty.
module uart_tx_arb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule
`endif

module uart_tx_arbiter #(
    parameter int IDLE_GAP = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       booting,
    input  logic [7:0] boot_data,
    input  logic       boot_transmit,
    output logic       boot_busy,
    output logic       boot_done,
    input  logic [7:0] cpu_data,
    input  logic       cpu_wr,
    output logic       cpu_full,
    output logic       cpu_done,
    output logic       cpu_ovf,
    output logic [7:0] tx_data,
    output logic       transmit,
    input  logic       tx_done,
    output logic       owner
);
    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_GAP} state_t;

    localparam int GW = (IDLE_GAP < 2) ? 1 : $clog2(IDLE_GAP + 1);

    state_t        state;
    logic [GW-1:0] gap_cnt;
    logic          last_cpu;
    logic [7:0]    boot_byte;
    logic          cpu_pend;
    logic [7:0]    cpu_head;
    logic          frame_end;
    logic          free_boot;
    logic          pop_cpu;
    logic          grant;
    logic          grant_cpu;

    assign frame_end = (state == S_WAIT) && tx_done;
    assign free_boot = frame_end && !owner;
    assign pop_cpu   = frame_end && owner;

    always_ff @(posedge clk) begin
        if (rst) begin
            boot_busy <= 1'b0;
            boot_byte <= '0;
        end else if (boot_transmit && !boot_busy) begin
            boot_busy <= 1'b1;
            boot_byte <= boot_data;
        end else if (free_boot) begin
            boot_busy <= 1'b0;
        end
    end

`ifdef UART_TX_ARB_CPU_FIFO_EN
    logic [2:0] cpu_count;

    uart_tx_arb_fifo #(.WIDTH(8), .DEPTH(4)) u_cpu_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cpu_wr),
        .push_data (cpu_data),
        .pop       (pop_cpu),
        .head      (cpu_head),
        .count     (cpu_count),
        .full      (cpu_full)
    );

    assign cpu_pend = (cpu_count != 3'd0);
`else
    logic [7:0] cpu_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_full <= 1'b0;
            cpu_byte <= '0;
        end else if (cpu_wr && !cpu_full) begin
            cpu_full <= 1'b1;
            cpu_byte <= cpu_data;
        end else if (pop_cpu) begin
            cpu_full <= 1'b0;
        end
    end

    assign cpu_pend = cpu_full;
    assign cpu_head = cpu_byte;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            cpu_ovf <= 1'b0;
        else if (cpu_wr && cpu_full)
            cpu_ovf <= 1'b1;
    end

    // Boot owns the UART while booting; otherwise a tie goes to whoever was not served last.
    always_comb begin
        grant     = 1'b0;
        grant_cpu = 1'b0;
        if (booting) begin
            grant = boot_busy;
        end else if (boot_busy && cpu_pend) begin
            grant     = 1'b1;
            grant_cpu = !last_cpu;
        end else if (boot_busy) begin
            grant = 1'b1;
        end else if (cpu_pend) begin
            grant     = 1'b1;
            grant_cpu = 1'b1;
        end
    end

    // The done-pulse cycle is never a grant cycle, so frames are spaced IDLE_GAP+3 apart even with IDLE_GAP=0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            gap_cnt   <= '0;
            last_cpu  <= 1'b1;
            owner     <= 1'b0;
            tx_data   <= '0;
            transmit  <= 1'b0;
            boot_done <= 1'b0;
            cpu_done  <= 1'b0;
        end else begin
            transmit  <= 1'b0;
            boot_done <= 1'b0;
            cpu_done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant && !boot_done && !cpu_done) begin
                        state    <= S_START;
                        transmit <= 1'b1;
                        owner    <= grant_cpu;
                        last_cpu <= grant_cpu;
                        tx_data  <= grant_cpu ? cpu_head : boot_byte;
                    end
                end
                S_START: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (tx_done) begin
                        boot_done <= !owner;
                        cpu_done  <= owner;
                        gap_cnt   <= '0;
                        state     <= (IDLE_GAP == 0) ? S_IDLE : S_GAP;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GW'(IDLE_GAP))
                        state <= S_IDLE;
                    else
                        gap_cnt <= gap_cnt + 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle-number reference model plus directed and random traffic.
module tb_uart_tx_arbiter;
    localparam int GAP = 2;
`ifdef UART_TX_ARB_CPU_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif

    logic       clk;
    logic       rst;
    logic       booting;
    logic [7:0] boot_data;
    logic       boot_transmit;
    logic       boot_busy;
    logic       boot_done;
    logic [7:0] cpu_data;
    logic       cpu_wr;
    logic       cpu_full;
    logic       cpu_done;
    logic       cpu_ovf;
    logic [7:0] tx_data;
    logic       transmit;
    logic       tx_done;
    logic       owner;

    uart_tx_arbiter #(.IDLE_GAP(GAP)) dut (
        .clk           (clk),
        .rst           (rst),
        .booting       (booting),
        .boot_data     (boot_data),
        .boot_transmit (boot_transmit),
        .boot_busy     (boot_busy),
        .boot_done     (boot_done),
        .cpu_data      (cpu_data),
        .cpu_wr        (cpu_wr),
        .cpu_full      (cpu_full),
        .cpu_done      (cpu_done),
        .cpu_ovf       (cpu_ovf),
        .tx_data       (tx_data),
        .transmit      (transmit),
        .tx_done       (tx_done),
        .owner         (owner)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    logic chk_en = 1'b0;

    // Reference model: slot contents as queues, frame timing as cycle numbers.
    logic       m_boot_pend;
    logic [7:0] m_boot_byte;
    logic [7:0] m_cpu_q[$];
    logic       m_last_cpu;
    logic       m_in_frame;
    logic       m_owner;
    int         m_tx_cycle;
    int         m_earliest;
    logic       e_transmit, e_boot_busy, e_boot_done, e_cpu_full, e_cpu_done, e_cpu_ovf, e_owner;
    logic [7:0] e_tx_data;

    always @(posedge clk) begin : mdl
        logic acc_b, acc_c, fin, gnt, gsel;
        int c;
        c = cyc;
        if (rst) begin
            m_boot_pend = 1'b0;
            m_cpu_q.delete();
            m_last_cpu  = 1'b1;
            m_in_frame  = 1'b0;
            m_owner     = 1'b0;
            m_earliest  = 0;
            e_transmit = 0; e_boot_busy = 0; e_boot_done = 0; e_cpu_full = 0;
            e_cpu_done = 0; e_cpu_ovf = 0; e_owner = 0; e_tx_data = 8'h00;
        end else begin
            acc_b = boot_transmit && !m_boot_pend;
            acc_c = cpu_wr && (m_cpu_q.size() < CAP);
            if (cpu_wr && !acc_c) e_cpu_ovf = 1'b1;
            fin = m_in_frame && (c > m_tx_cycle) && tx_done;
            gnt = 1'b0;
            gsel = 1'b0;
            if (!m_in_frame && c >= m_earliest) begin
                if (booting) gnt = m_boot_pend;
                else if (m_boot_pend && m_cpu_q.size() > 0) begin gnt = 1'b1; gsel = !m_last_cpu; end
                else if (m_boot_pend) gnt = 1'b1;
                else if (m_cpu_q.size() > 0) begin gnt = 1'b1; gsel = 1'b1; end
            end
            e_transmit  = gnt;
            e_boot_done = fin && !m_owner;
            e_cpu_done  = fin && m_owner;
            if (gnt) begin
                e_tx_data  = gsel ? m_cpu_q[0] : m_boot_byte;
                e_owner    = gsel;
                m_owner    = gsel;
                m_last_cpu = gsel;
                m_in_frame = 1'b1;
                m_tx_cycle = c + 1;
            end
            if (fin) begin
                m_in_frame = 1'b0;
                m_earliest = c + GAP + 2;
                if (!m_owner) m_boot_pend = 1'b0;
                else void'(m_cpu_q.pop_front());
            end
            if (acc_b) begin
                m_boot_pend = 1'b1;
                m_boot_byte = boot_data;
            end
            if (acc_c) m_cpu_q.push_back(cpu_data);
            e_boot_busy = m_boot_pend;
            e_cpu_full  = (m_cpu_q.size() == CAP);
        end
        cyc = cyc + 1;
    end

    // UART stand-in: tx_done a fixed or random number of cycles after transmit.
    logic u_stall = 1'b0;
    logic u_stray = 1'b0;
    int   u_fixed = 10;
    int   u_force_req = 0;
    int   u_force_ack = 0;
    logic u_busy;
    int   u_due;

    initial begin
        tx_done = 1'b0;
        u_busy  = 1'b0;
        u_due   = 0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (u_force_req != u_force_ack) begin
                tx_done = 1'b1;
                u_force_ack = u_force_req;
            end else if (rst) begin
                u_busy = 1'b0;
            end else if (u_busy) begin
                if (cyc >= u_due && !u_stall) begin
                    tx_done = 1'b1;
                    u_busy  = 1'b0;
                end
            end else if (transmit) begin
                u_busy = 1'b1;
                u_due  = cyc + ((u_fixed > 0) ? u_fixed : int'($urandom_range(1, 12)));
            end else if (u_stray && $urandom_range(0, 7) == 0) begin
                tx_done = 1'b1;
            end
        end
    end

    int         log_t[$];
    logic [7:0] log_d[$];

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Every cycle: compare all outputs against the model and log transmitted bytes.
    task automatic step();
        @(negedge clk);
        if (chk_en) begin
            cmp("transmit", {7'd0, transmit}, {7'd0, e_transmit});
            cmp("tx_data", tx_data, e_tx_data);
            cmp("owner", {7'd0, owner}, {7'd0, e_owner});
            cmp("boot_busy", {7'd0, boot_busy}, {7'd0, e_boot_busy});
            cmp("boot_done", {7'd0, boot_done}, {7'd0, e_boot_done});
            cmp("cpu_full", {7'd0, cpu_full}, {7'd0, e_cpu_full});
            cmp("cpu_done", {7'd0, cpu_done}, {7'd0, e_cpu_done});
            cmp("cpu_ovf", {7'd0, cpu_ovf}, {7'd0, e_cpu_ovf});
        end
        if (transmit) begin
            log_t.push_back(cyc);
            log_d.push_back(tx_data);
        end
    endtask

    task automatic wait_log(input int n, input int budget);
        for (int k = 0; k < budget && log_d.size() < n; k++) step();
        check("wait_log_count", log_d.size(), n);
    endtask

    task automatic wait_done(input int sel, output int t);
        t = -1;
        for (int k = 0; k < 200; k++) begin
            if ((sel == 0 && boot_done) || (sel == 1 && cpu_done)) begin
                t = cyc;
                break;
            end
            step();
        end
        if (t < 0) begin
            tests++;
            fails++;
            $display("FAIL wait_done sel=%0d: got timeout required pulse", sel);
        end
    endtask

    task automatic clear_log();
        log_t.delete();
        log_d.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1);
    end

    initial begin
        int n, t, k;
        int rst_hold;
        logic [7:0] exp_ovf[4];
        rst = 1'b1; booting = 1'b0; boot_data = 8'h00; boot_transmit = 1'b0;
        cpu_data = 8'h00; cpu_wr = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        check("rst_transmit", int'(transmit), 0);
        check("rst_tx_data", int'(tx_data), 0);
        check("rst_boot_busy", int'(boot_busy), 0);
        check("rst_cpu_full", int'(cpu_full), 0);
        check("rst_cpu_ovf", int'(cpu_ovf), 0);
        rst = 1'b0;
        step(); step();

        // Boot echo
        clear_log();
        booting = 1'b1; boot_data = 8'hA5; boot_transmit = 1'b1; n = cyc;
        step(); boot_transmit = 1'b0;
        wait_log(1, 20);
        check("echo_time", (log_t.size() > 0) ? log_t[0] : -1, n + 2);
        check("echo_data", (log_d.size() > 0) ? int'(log_d[0]) : -1, 8'hA5);
        wait_done(0, t);
        check("echo_done_time", t, n + 2 + 10 + 1);
        for (int i = 0; i < 6; i++) step();

        // CPU blocked while booting
        clear_log();
        cpu_data = 8'h41; cpu_wr = 1'b1;
        step(); cpu_wr = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("blocked_no_tx", log_d.size(), 0);
        booting = 1'b0;
        wait_log(1, 20);
        check("blocked_data", (log_d.size() > 0) ? int'(log_d[0]) : -1, 8'h41);
        check("blocked_owner", int'(owner), 1);
        wait_done(1, t);
        check("blocked_done_time", t, ((log_t.size() > 0) ? log_t[0] : 0) + 11);
        for (int i = 0; i < 6; i++) step();

        // Round-robin tie, twice, plus frame spacing
        clear_log();
        for (int r = 0; r < 2; r++) begin
            boot_data = 8'h11; boot_transmit = 1'b1; cpu_data = 8'h22; cpu_wr = 1'b1;
            step(); boot_transmit = 1'b0; cpu_wr = 1'b0;
            wait_log(2 * r + 2, 80);
            step();
            wait_done(1, t);
            step();
        end
        check("rr_0", (log_d.size() > 0) ? int'(log_d[0]) : -1, 8'h11);
        check("rr_1", (log_d.size() > 1) ? int'(log_d[1]) : -1, 8'h22);
        check("rr_2", (log_d.size() > 2) ? int'(log_d[2]) : -1, 8'h11);
        check("rr_3", (log_d.size() > 3) ? int'(log_d[3]) : -1, 8'h22);
        check("gap_cycles", (log_t.size() > 1) ? log_t[1] - (log_t[0] + 10) : -1, 5);
        for (int i = 0; i < 6; i++) step();

        // Overflow with the UART stalled
        clear_log();
        u_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cpu_data = 8'h31 + 8'(i); cpu_wr = 1'b1;
            step();
        end
        cpu_wr = 1'b0;
        step(); step();
        check("ovf_set", int'(cpu_ovf), 1);
        check("ovf_full", int'(cpu_full), 1);
        u_stall = 1'b0;
        wait_log(CAP, 300);
        for (int i = 0; i < 40; i++) step();
        check("ovf_sent_count", log_d.size(), CAP);
        exp_ovf[0] = 8'h31; exp_ovf[1] = 8'h32; exp_ovf[2] = 8'h33; exp_ovf[3] = 8'h34;
        for (int i = 0; i < CAP; i++)
            check("ovf_order", (log_d.size() > i) ? int'(log_d[i]) : -1, int'(exp_ovf[i]));

        // Reset mid-frame, then a stray tx_done
        clear_log();
        boot_data = 8'h77; boot_transmit = 1'b1;
        step(); boot_transmit = 1'b0;
        wait_log(1, 20);
        step(); step(); step();
        rst = 1'b1;
        step(); step();
        check("mid_rst_transmit", int'(transmit), 0);
        check("mid_rst_tx_data", int'(tx_data), 0);
        check("mid_rst_owner", int'(owner), 0);
        check("mid_rst_boot_busy", int'(boot_busy), 0);
        check("mid_rst_cpu_ovf", int'(cpu_ovf), 0);
        rst = 1'b0;
        u_force_req = u_force_req + 1;
        k = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (boot_done || cpu_done) k++;
        end
        check("stray_no_done", k, 0);

        // Random traffic
        u_fixed = 0; u_stray = 1'b1; rst_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            boot_transmit = ($urandom_range(0, 5) == 0);
            boot_data     = 8'($urandom);
            cpu_wr        = ($urandom_range(0, 3) == 0);
            cpu_data      = 8'($urandom);
            if ($urandom_range(0, 39) == 0) booting = ~booting;
            if ($urandom_range(0, 99) == 0) u_stall = ~u_stall;
            if (rst_hold > 0) begin
                rst = 1'b1;
                rst_hold--;
            end else begin
                rst = 1'b0;
                if ($urandom_range(0, 799) == 0) rst_hold = 2;
            end
        end
        boot_transmit = 1'b0; cpu_wr = 1'b0; booting = 1'b0; u_stall = 1'b0; rst = 1'b0;
        for (int i = 0; i < 150; i++) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
